windowed_rf_spill: RTL and testbench

Parametrised windowed register file with call/return window rotation and automatic spill/fill of the oldest window to a LIFO backing memory. It generalises the fixed globals/IN/LOCAL/OUT register file to any N, F and M with two registered read ports. The block sits between the integer datapath and the data-memory stack port. A dedicated FSM spills or fills one window when a CALL would overflow the window set or a RET would underflow it.

---
 rtl/windowed_rf_spill_pkg.sv | 29 ++
 rtl/rf_addr_xlate.sv | 61 ++++++
 rtl/windowed_rf_spill.sv | 224 ++++++++++++++++++++++
 tb/tb_windowed_rf_spill.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/windowed_rf_spill_pkg.sv
// rtl/windowed_rf_spill_pkg.sv - shared types and helpers for the windowed register file
package windowed_rf_spill_pkg;

    localparam int DEF_NBITS      = 64;
    localparam int DEF_N          = 3;
    localparam int DEF_F          = 4;
    localparam int DEF_M          = 5;
    localparam int DEF_DEPTH_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SPILL,
        ST_FILL
    } state_e;

    typedef enum logic [2:0] {
        SEC_GLOBAL,
        SEC_IN,
        SEC_LOCAL,
        SEC_OUT,
        SEC_INVALID
    } sect_e;

    // Physical word count: globals plus IN/LOCAL block pairs for every window.
    function automatic int phys_words(input int m, input int n, input int f);
        return m + 2 * n * f;
    endfunction

endpackage

// File: rtl/rf_addr_xlate.sv
// rtl/rf_addr_xlate.sv - logical register address plus window pointer to physical index
// Ports:
//   addr_i  : logical address (globals, IN, LOCAL, OUT)
//   cwp_i   : window whose view is used for the translation
//   idx_o   : physical word index
//   valid_o : address falls inside the logical map
module rf_addr_xlate
    import windowed_rf_spill_pkg::*;
#(
    parameter int N         = DEF_N,
    parameter int F         = DEF_F,
    parameter int M         = DEF_M,
    parameter int ADDR_SIZE = 4,
    parameter int PW        = 5,
    parameter int CW        = 2
) (
    input  logic [ADDR_SIZE-1:0] addr_i,
    input  logic [CW-1:0]        cwp_i,
    output logic [PW-1:0]        idx_o,
    output logic                 valid_o
);

    sect_e sect;
    int    a;
    int    w;
    int    blk;
    int    off;
    int    phys;

    always_comb begin
        sect = SEC_INVALID;
        a    = int'(addr_i);
        w    = int'(cwp_i);
        blk  = 0;
        off  = 0;
        phys = 0;
        if (a < M) begin
            sect = SEC_GLOBAL;
            phys = a;
        end else if (a < M + N) begin
            sect = SEC_IN;
            off  = a - M;
            blk  = 2 * w;
        end else if (a < M + 2 * N) begin
            sect = SEC_LOCAL;
            off  = a - M - N;
            blk  = 2 * w + 1;
        end else if (a < M + 3 * N) begin
            // OUT wraps onto the IN block of the next window (window F-1 -> block 0).
            sect = SEC_OUT;
            off  = a - M - 2 * N;
            blk  = (2 * w + 2) % (2 * F);
        end
        if (sect != SEC_GLOBAL && sect != SEC_INVALID) begin
            phys = M + blk * N + off;
        end
        idx_o   = PW'(phys);
        valid_o = (sect != SEC_INVALID);
    end

endmodule

// File: rtl/windowed_rf_spill.sv
// rtl/windowed_rf_spill.sv - windowed register file with call/ret rotation and spill/fill FSM
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   en, rd1, rd2, wr                : enable and port strobes
//   add_rd1, add_rd2, add_wr, datain: logical addresses and write data
//   out1, out2                      : registered read data
//   call, ret                       : window push / pop
//   busy, err                       : spill/fill in progress, one-cycle error pulse
//   spill_valid/spill_data/spill_ready : outgoing oldest-window stream
//   fill_req/fill_valid/fill_data   : incoming window restore stream
module windowed_rf_spill
    import windowed_rf_spill_pkg::*;
#(
    parameter int NBITS      = DEF_NBITS,
    parameter int N          = DEF_N,
    parameter int F          = DEF_F,
    parameter int M          = DEF_M,
    parameter int DEPTH_BITS = DEF_DEPTH_BITS,
    localparam int ADDR_SIZE = $clog2(3 * N + M + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 rd1,
    input  logic                 rd2,
    input  logic                 wr,
    input  logic [ADDR_SIZE-1:0] add_rd1,
    input  logic [ADDR_SIZE-1:0] add_rd2,
    input  logic [ADDR_SIZE-1:0] add_wr,
    input  logic [NBITS-1:0]     datain,
    output logic [NBITS-1:0]     out1,
    output logic [NBITS-1:0]     out2,
    input  logic                 call,
    input  logic                 ret,
    output logic                 busy,
    output logic                 err,
    output logic                 spill_valid,
    output logic [NBITS-1:0]     spill_data,
    input  logic                 spill_ready,
    output logic                 fill_req,
    input  logic                 fill_valid,
    input  logic [NBITS-1:0]     fill_data
);

    localparam int PHYS_REGS = phys_words(M, N, F);
    localparam int PW        = $clog2(PHYS_REGS);
    localparam int CW        = $clog2(F);
    localparam int CNTW      = $clog2(2 * N);
    localparam logic [CW-1:0]   LAST_W    = CW'(F - 1);
    localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(2 * N - 1);

    logic [NBITS-1:0]      rf_q [PHYS_REGS];
    state_e                state_q, state_d;
    logic [CW-1:0]         cwp_q, cwp_d;
    logic [CW-1:0]         swp_q, swp_d;
    logic [CW-1:0]         occ_q, occ_d;
    logic [DEPTH_BITS-1:0] depth_q, depth_d;
    logic [CNTW-1:0]       cnt_q, cnt_d;
    logic [NBITS-1:0]      out1_q, out2_q;
    logic                  err_q, err_d;

    logic [PW-1:0]        idx1, idx2, idxw, idxx;
    logic                 v1, v2, vw, vx;
    logic [ADDR_SIZE-1:0] xaddr;
    logic [CW-1:0]        xcwp;
    logic                 act, do_rd1, do_rd2, do_wr;
    logic [NBITS-1:0]     rdata1, rdata2;

    function automatic logic [CW-1:0] inc_w(input logic [CW-1:0] v);
        return (v == LAST_W) ? '0 : v + 1'b1;
    endfunction

    function automatic logic [CW-1:0] dec_w(input logic [CW-1:0] v);
        return (v == '0) ? LAST_W : v - 1'b1;
    endfunction

    rf_addr_xlate #(.N(N), .F(F), .M(M), .ADDR_SIZE(ADDR_SIZE), .PW(PW), .CW(CW)) u_xl_rd1 (
        .addr_i(add_rd1), .cwp_i(cwp_q), .idx_o(idx1), .valid_o(v1));
    rf_addr_xlate #(.N(N), .F(F), .M(M), .ADDR_SIZE(ADDR_SIZE), .PW(PW), .CW(CW)) u_xl_rd2 (
        .addr_i(add_rd2), .cwp_i(cwp_q), .idx_o(idx2), .valid_o(v2));
    rf_addr_xlate #(.N(N), .F(F), .M(M), .ADDR_SIZE(ADDR_SIZE), .PW(PW), .CW(CW)) u_xl_wr (
        .addr_i(add_wr), .cwp_i(cwp_q), .idx_o(idxw), .valid_o(vw));
    rf_addr_xlate #(.N(N), .F(F), .M(M), .ADDR_SIZE(ADDR_SIZE), .PW(PW), .CW(CW)) u_xl_xfer (
        .addr_i(xaddr), .cwp_i(xcwp), .idx_o(idxx), .valid_o(vx));

    // Spill walks IN[0..N-1] then LOCAL[0..N-1] of the oldest window, which are
    // contiguous logical addresses M..M+2N-1. Fill walks the same range backwards
    // into the window just below CWP.
    always_comb begin
        xaddr = ADDR_SIZE'(M) + ADDR_SIZE'(cnt_q);
        xcwp  = swp_q;
        if (state_q == ST_FILL) begin
            xaddr = ADDR_SIZE'(M + 2 * N - 1) - ADDR_SIZE'(cnt_q);
            xcwp  = dec_w(cwp_q);
        end
    end

    assign act    = en && (state_q == ST_IDLE);
    assign do_rd1 = act && rd1;
    assign do_rd2 = act && rd2;
    assign do_wr  = act && wr;

    // Write-first bypass when a read targets the word being written this cycle.
    assign rdata1 = !v1 ? '0 : (do_wr && vw && idxw == idx1) ? datain : rf_q[idx1];
    assign rdata2 = !v2 ? '0 : (do_wr && vw && idxw == idx2) ? datain : rf_q[idx2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PHYS_REGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (do_wr && vw) begin
            rf_q[idxw] <= datain;
        end else if (state_q == ST_FILL && fill_valid && vx) begin
            rf_q[idxx] <= fill_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out1_q <= '0;
            out2_q <= '0;
        end else begin
            if (do_rd1) out1_q <= rdata1;
            if (do_rd2) out2_q <= rdata2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cwp_q   <= '0;
            swp_q   <= '0;
            occ_q   <= CW'(1);
            depth_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cwp_q   <= cwp_d;
            swp_q   <= swp_d;
            occ_q   <= occ_d;
            depth_q <= depth_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cwp_d   = cwp_q;
        swp_d   = swp_q;
        occ_d   = occ_q;
        depth_d = depth_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (act) begin
                    if (call && ret) begin
                        err_d = 1'b1;
                    end else if (call) begin
                        if (occ_q != LAST_W) begin
                            cwp_d = inc_w(cwp_q);
                            occ_d = occ_q + 1'b1;
                        end else if (depth_q == '1) begin
                            err_d = 1'b1;
                        end else begin
                            state_d = ST_SPILL;
                            cnt_d   = '0;
                        end
                    end else if (ret) begin
                        if (occ_q != CW'(1)) begin
                            cwp_d = dec_w(cwp_q);
                            occ_d = occ_q - 1'b1;
                        end else if (depth_q == '0) begin
                            err_d = 1'b1;
                        end else begin
                            state_d = ST_FILL;
                            cnt_d   = '0;
                        end
                    end
                    if (wr && !vw) err_d = 1'b1;
                end
            end
            ST_SPILL: begin
                if (spill_ready) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        swp_d   = inc_w(swp_q);
                        cwp_d   = inc_w(cwp_q);
                        depth_d = depth_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_FILL: begin
                if (fill_valid) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        swp_d   = dec_w(swp_q);
                        cwp_d   = dec_w(cwp_q);
                        depth_d = depth_q - 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign out1        = out1_q;
    assign out2        = out2_q;
    assign err         = err_q;
    assign busy        = (state_q != ST_IDLE);
    assign spill_valid = (state_q == ST_SPILL);
    assign spill_data  = spill_valid ? rf_q[idxx] : '0;
    assign fill_req    = (state_q == ST_FILL);

endmodule

// File: tb/tb_windowed_rf_spill.sv
// tb/tb_windowed_rf_spill.sv - directed self-checking bench for windowed_rf_spill
module tb_windowed_rf_spill;

    localparam int NBITS = 64;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             rd1 = 1'b0;
    logic             rd2 = 1'b0;
    logic             wr = 1'b0;
    logic [AW-1:0]    add_rd1 = '0;
    logic [AW-1:0]    add_rd2 = '0;
    logic [AW-1:0]    add_wr = '0;
    logic [NBITS-1:0] datain = '0;
    logic             call = 1'b0;
    logic             ret = 1'b0;
    logic             spill_ready = 1'b0;
    logic             fill_valid = 1'b0;
    logic [NBITS-1:0] fill_data = '0;
    logic [NBITS-1:0] out1, out2, spill_data;
    logic             busy, err, spill_valid, fill_req;

    int               n_checks = 0;
    int               n_errors = 0;
    logic [NBITS-1:0] win_val [6];
    logic [NBITS-1:0] e_val [6];

    always #5 clk = ~clk;

    windowed_rf_spill dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .rd1(rd1), .rd2(rd2), .wr(wr),
        .add_rd1(add_rd1), .add_rd2(add_rd2), .add_wr(add_wr),
        .datain(datain), .out1(out1), .out2(out2),
        .call(call), .ret(ret), .busy(busy), .err(err),
        .spill_valid(spill_valid), .spill_data(spill_data), .spill_ready(spill_ready),
        .fill_req(fill_req), .fill_valid(fill_valid), .fill_data(fill_data)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [AW-1:0] a, input logic [NBITS-1:0] d);
        wr = 1'b1; add_wr = a; datain = d;
        step();
        wr = 1'b0;
    endtask

    task automatic rd_chk(input logic [AW-1:0] a, input logic [NBITS-1:0] exp, input string tag);
        rd1 = 1'b1; add_rd1 = a;
        step();
        rd1 = 1'b0;
        check(tag, out1, exp);
    endtask

    initial begin
        for (int k = 0; k < 6; k++) begin
            win_val[k] = 64'hA5A5_0000_0000_0000 + 64'(k) * 64'h0000_0101_0000_1001;
            e_val[k]   = ~win_val[k];
        end

        // Reset state
        step(); step();
        check("rst_out1", out1, 0);
        check("rst_out2", out2, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_spill_valid", spill_valid, 0);
        check("rst_spill_data", spill_data, 0);
        check("rst_fill_req", fill_req, 0);
        check("rst_cwp", dut.cwp_q, 0);
        check("rst_occ", dut.occ_q, 1);
        rst_n = 1'b1; en = 1'b1;
        step();

        // Global write, dual-port read
        wr_reg(4'd0, 64'hA5);
        rd1 = 1'b1; rd2 = 1'b1; add_rd1 = 4'd0; add_rd2 = 4'd0;
        step();
        rd1 = 1'b0; rd2 = 1'b0;
        check("glob_out1", out1, 64'hA5);
        check("glob_out2", out2, 64'hA5);
        check("glob_cwp", dut.cwp_q, 0);

        // Same-cycle read/write of one word returns the new data
        wr = 1'b1; add_wr = 4'd1; datain = 64'h77; rd1 = 1'b1; add_rd1 = 4'd1;
        step();
        wr = 1'b0; rd1 = 1'b0;
        check("write_first", out1, 64'h77);

        // OUT of window 0 aliases IN of window 1
        wr_reg(4'd11, 64'h11);
        call = 1'b1;
        step();
        call = 1'b0;
        rd_chk(4'd5, 64'h11, "alias_in0");
        check("alias_cwp1", dut.cwp_q, 1);
        check("alias_occ2", dut.occ_q, 2);
        ret = 1'b1;
        step();
        ret = 1'b0;
        rd_chk(4'd11, 64'h11, "alias_out0");
        check("alias_cwp0", dut.cwp_q, 0);

        // Spill of window 0 with two stall cycles per beat
        for (int k = 0; k < 6; k++) wr_reg(4'(5 + k), win_val[k]);
        call = 1'b1;
        step(); step(); step();
        call = 1'b0;
        check("spill_busy_rise", busy, 1);
        for (int b = 0; b < 6; b++) begin
            spill_ready = 1'b0;
            if (b == 0) begin
                call = 1'b1; rd1 = 1'b1; add_rd1 = 4'd0;
            end
            for (int s = 0; s < 2; s++) begin
                check($sformatf("spill_hold_b%0d", b), spill_data, win_val[b]);
                check($sformatf("spill_busy_b%0d", b), busy, 1);
                step();
            end
            call = 1'b0; rd1 = 1'b0;
            spill_ready = 1'b1;
            check($sformatf("spill_valid_b%0d", b), spill_valid, 1);
            check($sformatf("spill_beat_b%0d", b), spill_data, win_val[b]);
            step();
        end
        spill_ready = 1'b0;
        check("spill_busy_fall", busy, 0);
        check("spill_valid_fall", spill_valid, 0);
        check("spill_swp", dut.swp_q, 1);
        check("spill_cwp", dut.cwp_q, 3);
        check("spill_occ", dut.occ_q, 3);
        check("spill_depth", dut.depth_q, 1);
        check("spill_out1_hold", out1, 64'h11);

        // Clobber window 0 IN through window 3 OUT, then fill it back
        for (int k = 0; k < 3; k++) wr_reg(4'(11 + k), 64'hBAD0 + 64'(k));
        ret = 1'b1;
        step(); step(); step();
        ret = 1'b0;
        check("fill_busy_rise", busy, 1);
        check("fill_req_rise", fill_req, 1);
        check("fill_cwp_hold", dut.cwp_q, 1);
        for (int b = 0; b < 6; b++) begin
            fill_valid = 1'b0;
            check($sformatf("fill_req_b%0d", b), fill_req, 1);
            step();
            fill_valid = 1'b1; fill_data = win_val[5 - b];
            step();
        end
        fill_valid = 1'b0;
        check("fill_busy_fall", busy, 0);
        check("fill_req_fall", fill_req, 0);
        check("fill_cwp", dut.cwp_q, 0);
        check("fill_swp", dut.swp_q, 0);
        check("fill_depth", dut.depth_q, 0);
        check("fill_occ", dut.occ_q, 1);
        for (int k = 0; k < 6; k++) rd_chk(4'(5 + k), win_val[k], $sformatf("fill_restore_%0d", k));

        // Error cases
        ret = 1'b1;
        step();
        ret = 1'b0;
        check("err_ret_underflow", err, 1);
        check("err_ret_cwp", dut.cwp_q, 0);
        step();
        check("err_one_cycle", err, 0);
        call = 1'b1; ret = 1'b1;
        step();
        call = 1'b0; ret = 1'b0;
        check("err_call_ret", err, 1);
        check("err_call_ret_cwp", dut.cwp_q, 0);
        check("err_call_ret_occ", dut.occ_q, 1);
        rd_chk(4'd0, 64'hA5, "rd_glob_again");
        rd_chk(4'd14, 64'h0, "rd_invalid");
        wr = 1'b1; add_wr = 4'd15; datain = 64'hFFFF;
        step();
        wr = 1'b0;
        check("err_wr_invalid", err, 1);

        // Reset in the middle of a spill
        rd1 = 1'b1; rd2 = 1'b1; add_rd1 = 4'd0; add_rd2 = 4'd5;
        step();
        rd1 = 1'b0; rd2 = 1'b0;
        check("pre_rst_out2", out2, win_val[0]);
        call = 1'b1;
        step(); step(); step();
        call = 1'b0;
        spill_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            check($sformatf("rst_spill_b%0d", b), spill_data, win_val[b]);
            if (b < 2) step();
        end
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_spill_valid", spill_valid, 0);
        check("midrst_spill_data", spill_data, 0);
        check("midrst_out1", out1, 0);
        check("midrst_out2", out2, 0);
        check("midrst_fill_req", fill_req, 0);
        spill_ready = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        check("midrst_depth", dut.depth_q, 0);
        for (int k = 0; k < 6; k++) wr_reg(4'(5 + k), e_val[k]);
        call = 1'b1;
        step(); step(); step();
        call = 1'b0;
        spill_ready = 1'b1;
        for (int b = 0; b < 6; b++) begin
            check($sformatf("clean_valid_b%0d", b), spill_valid, 1);
            check($sformatf("clean_beat_b%0d", b), spill_data, e_val[b]);
            step();
        end
        check("clean_busy_fall", busy, 0);
        check("clean_depth", dut.depth_q, 1);

        // Depth saturation: 254 more spills reach the maximum, then a spill-call errors
        for (int i = 0; i < 254; i++) begin
            int k;
            call = 1'b1;
            step();
            call = 1'b0;
            k = 0;
            while (busy && k < 20) begin
                step();
                k++;
            end
            if (k >= 20) begin
                check("sat_spill_timeout", busy, 0);
                break;
            end
        end
        check("sat_depth", dut.depth_q, 255);
        call = 1'b1;
        step();
        call = 1'b0;
        check("sat_err", err, 1);
        check("sat_busy", busy, 0);
        check("sat_depth_hold", dut.depth_q, 255);
        check("sat_cwp", dut.cwp_q, 1);
        check("sat_swp", dut.swp_q, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
